// File: rtl/issue_scoreboard.sv
// Dual-issue read-operand scoreboard: blocks load-use, long-op RAW/WAW, intra-pair RAW and long-unit conflicts.
// Slot B issue and its state updates exist only when DUAL_ISSUE_SB_EN is defined.
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       ex_stall,
  input  logic       a_valid,
  input  logic [4:0] a_src1,
  input  logic [4:0] a_src2,
  input  logic       a_src1_used,
  input  logic       a_src2_used,
  input  logic [4:0] a_dest,
  input  logic [1:0] a_lat,
  input  logic       b_valid,
  input  logic [4:0] b_src1,
  input  logic [4:0] b_src2,
  input  logic       b_src1_used,
  input  logic       b_src2_used,
  input  logic [4:0] b_dest,
  input  logic [1:0] b_lat,
  input  logic       long_done,
  output logic       issue_a,
  output logic       issue_b,
  output logic       ro_hold,
  output logic       long_busy,
  output logic       long_abort
);

  typedef enum logic {S_IDLE, S_BUSY} long_state_e;

  localparam logic [1:0]       LAT_LOAD = 2'd1;
  localparam logic [1:0]       LAT_LONG = 2'd2;
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] r_lpend;
  logic [4:0]          r_ldest;
  long_state_e         r_state;
  long_state_e         w_state_nxt;

  logic w_busy;
  logic w_issue_a;
  logic w_issue_b;
  logic w_acc_a;
  logic w_acc_b;
  logic w_long_acc;

  function automatic logic f_pending(input logic [4:0] r);
    return (r != 5'd0) && ((r_cnt[r] != '0) || r_lpend[r]);
  endfunction

  assign w_busy = (r_state == S_BUSY);

  assign w_issue_a = a_valid
                   && !(a_src1_used && f_pending(a_src1))
                   && !(a_src2_used && f_pending(a_src2))
                   && !((a_dest != 5'd0) && r_lpend[a_dest])
                   && !((a_lat == LAT_LONG) && w_busy);

`ifdef DUAL_ISSUE_SB_EN
  // B is younger: it also waits on A's result and may not share the long unit with A.
  assign w_issue_b = w_issue_a && b_valid
                   && !(b_src1_used && f_pending(b_src1))
                   && !(b_src2_used && f_pending(b_src2))
                   && !((b_dest != 5'd0) && r_lpend[b_dest])
                   && !((a_dest != 5'd0) && ((b_src1_used && (b_src1 == a_dest)) ||
                                             (b_src2_used && (b_src2 == a_dest))))
                   && !((b_lat == LAT_LONG) && (w_busy || (a_lat == LAT_LONG)));
`else
  logic w_unused_b;
  assign w_unused_b = ^{b_src1, b_src2, b_src1_used, b_src2_used, b_dest, b_lat};
  assign w_issue_b  = 1'b0;
`endif

  assign issue_a    = reset && w_issue_a;
  assign issue_b    = reset && w_issue_b;
  assign ro_hold    = reset && ((a_valid && !w_issue_a) || (b_valid && !w_issue_b));
  assign long_busy  = reset && w_busy;
  assign long_abort = reset && flush && w_busy;

  assign w_acc_a    = w_issue_a && !ex_stall && !flush;
  assign w_acc_b    = w_issue_b && !ex_stall && !flush;
  assign w_long_acc = (w_acc_a && (a_lat == LAT_LONG)) || (w_acc_b && (b_lat == LAT_LONG));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_long_acc) w_state_nxt = S_BUSY;
        S_BUSY:  if (long_done)  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: the counter/pending arrays are control state, not data storage, so they are reset like any flop.
  // NOTE: non-blocking assignments; later writes in this block override earlier ones in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
      r_lpend <= '0;
      if (!reset) r_ldest <= '0;
    end else begin
      if (!ex_stall) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end

      if (w_busy && long_done) r_lpend[r_ldest] <= 1'b0;

      if (w_acc_a && (a_dest != 5'd0) && (a_lat == LAT_LOAD)) r_cnt[a_dest] <= LOAD_CNT;
      if (w_acc_a && (a_lat == LAT_LONG)) begin
        if (a_dest != 5'd0) r_lpend[a_dest] <= 1'b1;
        r_ldest <= a_dest;
      end

`ifdef DUAL_ISSUE_SB_EN
      // Slot B is program-order younger, so its update to a shared destination wins.
      if (w_acc_b && (b_dest != 5'd0)) begin
        if (b_lat == LAT_LOAD) begin
          r_cnt[b_dest] <= LOAD_CNT;
        end else if ((b_lat != LAT_LONG) && w_acc_a && (b_dest == a_dest)) begin
          r_cnt[b_dest] <= '0;
        end
      end
      if (w_acc_b && (b_lat == LAT_LONG)) begin
        if (b_dest != 5'd0) r_lpend[b_dest] <= 1'b1;
        r_ldest <= b_dest;
      end
`endif
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed hazard scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the issue rules.
module tb_issue_scoreboard;

  localparam int LOAD_LAT = 2;

  logic       clk = 1'b0;
  logic       reset, flush, ex_stall, long_done;
  logic       a_valid, a_src1_used, a_src2_used;
  logic [4:0] a_src1, a_src2, a_dest;
  logic [1:0] a_lat;
  logic       b_valid, b_src1_used, b_src2_used;
  logic [4:0] b_src1, b_src2, b_dest;
  logic [1:0] b_lat;
  logic       issue_a, issue_b, ro_hold, long_busy, long_abort;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: load cycles left before a register is forwardable, long-op pending flags.
  int m_wait [32];
  bit m_lp   [32];
  int m_ld;
  bit m_busy;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_stall(ex_stall),
    .a_valid(a_valid), .a_src1(a_src1), .a_src2(a_src2),
    .a_src1_used(a_src1_used), .a_src2_used(a_src2_used), .a_dest(a_dest), .a_lat(a_lat),
    .b_valid(b_valid), .b_src1(b_src1), .b_src2(b_src2),
    .b_src1_used(b_src1_used), .b_src2_used(b_src2_used), .b_dest(b_dest), .b_lat(b_lat),
    .long_done(long_done),
    .issue_a(issue_a), .issue_b(issue_b), .ro_hold(ro_hold),
    .long_busy(long_busy), .long_abort(long_abort)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  function automatic bit m_blocked(input logic [4:0] r);
    return (r != 5'd0) && (m_wait[r] > 0 || m_lp[r]);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_wait[i] = 0;
      m_lp[i]   = 1'b0;
    end
    m_busy = 1'b0;
  endtask

  task automatic m_start_long(input logic [4:0] d);
    if (d != 5'd0) m_lp[d] = 1'b1;
    m_ld   = d;
    m_busy = 1'b1;
  endtask

  // Checks all outputs at the falling edge, then advances the model across the rising edge.
  task automatic step(input string tag);
    bit ea, eb, eh;
    @(negedge clk);
    ea = reset && a_valid
         && !(a_src1_used && m_blocked(a_src1)) && !(a_src2_used && m_blocked(a_src2))
         && !(a_dest != 0 && m_lp[a_dest]) && !(a_lat == 2 && m_busy);
`ifdef DUAL_ISSUE_SB_EN
    eb = ea && b_valid
         && !(b_src1_used && m_blocked(b_src1)) && !(b_src2_used && m_blocked(b_src2))
         && !(b_dest != 0 && m_lp[b_dest])
         && !(a_dest != 0 && ((b_src1_used && b_src1 == a_dest) || (b_src2_used && b_src2 == a_dest)))
         && !(b_lat == 2 && (m_busy || a_lat == 2));
`else
    eb = 1'b0;
`endif
    eh = reset && ((a_valid && !ea) || (b_valid && !eb));
    check({tag, ".issue_a"},    issue_a,    ea);
    check({tag, ".issue_b"},    issue_b,    eb);
    check({tag, ".ro_hold"},    ro_hold,    eh);
    check({tag, ".long_busy"},  long_busy,  reset && m_busy);
    check({tag, ".long_abort"}, long_abort, reset && flush && m_busy);

    if (!reset) begin
      m_clear();
      m_ld = 0;
    end else if (flush) begin
      m_clear();
    end else begin
      if (m_busy && long_done) begin
        m_busy = 1'b0;
        m_lp[m_ld] = 1'b0;
      end
      if (!ex_stall) begin
        for (int i = 1; i < 32; i++) if (m_wait[i] > 0) m_wait[i]--;
        if (ea) begin
          if (a_lat == 1 && a_dest != 0) m_wait[a_dest] = LOAD_LAT;
          if (a_lat == 2) m_start_long(a_dest);
        end
        if (eb) begin
          if (b_lat == 1 && b_dest != 0) m_wait[b_dest] = LOAD_LAT;
          else if (b_lat != 2 && b_dest != 0 && ea && b_dest == a_dest) m_wait[b_dest] = 0;
          if (b_lat == 2) m_start_long(b_dest);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic [4:0] d, input logic [1:0] l);
    a_valid = v; a_src1 = s1; a_src1_used = u1; a_src2 = s2; a_src2_used = u2; a_dest = d; a_lat = l;
  endtask

  task automatic set_b(input logic v, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic [4:0] d, input logic [1:0] l);
    b_valid = v; b_src1 = s1; b_src1_used = u1; b_src2 = s2; b_src2_used = u2; b_dest = d; b_lat = l;
  endtask

  task automatic idle();
    set_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    set_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    flush = 1'b0; ex_stall = 1'b0; long_done = 1'b0;
  endtask

  initial begin
    m_clear();
    m_ld = 0;
    reset = 1'b0;
    idle();
    set_a(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 2'd2);
    #1;
    check("rst.issue_a", issue_a, 1'b0);
    check("rst.ro_hold", ro_hold, 1'b0);
    step("rst0");
    step("rst1");
    reset = 1'b1;
    idle();

    // Load-use: add r6,r5,r1 waits LOAD_LAT cycles behind load r5.
    set_a(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 2'd1);
    #1; check("s1.load_issue", issue_a, 1'b1);
    step("s1a");
    set_a(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 2'd0);
    #1; check("s1.use_wait1", issue_a, 1'b0);
    step("s1b");
    #1; check("s1.use_wait2", issue_a, 1'b0);
    step("s1c");
    #1; check("s1.use_go", issue_a, 1'b1);
    step("s1d");
    idle();

    // Intra-pair RAW: B reads A's destination.
    set_a(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 2'd0);
    set_b(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 2'd0);
    #1;
    check("s2.issue_a", issue_a, 1'b1);
    check("s2.issue_b", issue_b, 1'b0);
    check("s2.ro_hold", ro_hold, 1'b1);
    step("s2a");
    set_a(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 2'd0);
    set_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    #1; check("s2.b_moved", issue_a, 1'b1);
    step("s2b");
    idle();

    // Long unit: div r9 blocks a second long op until long_done.
    set_a(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 2'd2);
    step("s3a");
    set_a(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 2'd2);
    #1;
    check("s3.mul_blocked", issue_a, 1'b0);
    check("s3.busy", long_busy, 1'b1);
    step("s3b");
    long_done = 1'b1;
    step("s3c");
    long_done = 1'b0;
    #1;
    check("s3.mul_go", issue_a, 1'b1);
    check("s3.idle", long_busy, 1'b0);
    set_a(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 2'd0);
    #1; check("s3.r9_free", issue_a, 1'b1);
    step("s3d");
    idle();

    // Load under ex_stall: counter frozen for 3 cycles, then two more cycles to drain.
    set_a(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 2'd1);
    step("s4a");
    set_a(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd12, 2'd0);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; check("s4.stall_block", issue_a, 1'b0);
      step("s4s");
    end
    ex_stall = 1'b0;
    #1; check("s4.rel_wait1", issue_a, 1'b0);
    step("s4b");
    #1; check("s4.rel_wait2", issue_a, 1'b0);
    step("s4c");
    #1; check("s4.rel_go", issue_a, 1'b1);
    step("s4d");
    idle();

    // Flush while the long unit is busy.
    set_a(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 2'd2);
    step("s5a");
    idle();
    flush = 1'b1;
    #1; check("s5.abort", long_abort, 1'b1);
    step("s5b");
    flush = 1'b0;
    set_a(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 2'd0);
    #1;
    check("s5.not_busy", long_busy, 1'b0);
    check("s5.r9_go", issue_a, 1'b1);
    step("s5c");
    idle();

    // r0 is never pending, even behind a load that names it.
    set_a(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 2'd1);
    set_b(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 2'd0);
    #1;
    check("s6.a_r0", issue_a, 1'b1);
`ifdef DUAL_ISSUE_SB_EN
    check("s6.b_r0", issue_b, 1'b1);
`else
    check("s6.b_off", issue_b, 1'b0);
`endif
    step("s6a");
    set_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    set_a(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd14, 2'd0);
    #1; check("s6.a_r0_next", issue_a, 1'b1);
    step("s6b");

    // Random traffic over a small register window to provoke frequent hazards.
    for (int i = 0; i < 800; i++) begin
      reset     = !(i >= 400 && i < 402);
      flush     = ($urandom_range(29) == 0);
      ex_stall  = ($urandom_range(4) == 0);
      long_done = m_busy ? ($urandom_range(3) == 0) : ($urandom_range(9) == 0);
      set_a($urandom_range(7) != 0, 5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)),
            1'($urandom), 5'($urandom_range(7)), 2'($urandom));
      set_b($urandom_range(7) != 0, 5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)),
            1'($urandom), 5'($urandom_range(7)), 2'($urandom));
      if ((a_lat == 2 || b_lat == 2) && b_dest != 0 && b_dest == a_dest) b_dest = a_dest ^ 5'd1;
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
